// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, coordinate type and the colour-bar palette (RRRGGGBB).
package vga_pkg;

  localparam int unsigned COORD_W = 10;
  typedef logic [COORD_W-1:0] coord_t;

  localparam int unsigned H_VIS  = 640;
  localparam int unsigned H_FP   = 16;
  localparam int unsigned H_SYNC = 96;
  localparam int unsigned H_BP   = 48;
  localparam int unsigned H_TOT  = H_VIS + H_FP + H_SYNC + H_BP;

  localparam int unsigned V_VIS  = 480;
  localparam int unsigned V_FP   = 10;
  localparam int unsigned V_SYNC = 2;
  localparam int unsigned V_BP   = 33;
  localparam int unsigned V_TOT  = V_VIS + V_FP + V_SYNC + V_BP;

  localparam logic [7:0] COL_WHITE   = 8'hFF;
  localparam logic [7:0] COL_YELLOW  = 8'hFC;
  localparam logic [7:0] COL_CYAN    = 8'h1F;
  localparam logic [7:0] COL_GREEN   = 8'h1C;
  localparam logic [7:0] COL_MAGENTA = 8'hE3;
  localparam logic [7:0] COL_RED     = 8'hE0;
  localparam logic [7:0] COL_BLUE    = 8'h03;
  localparam logic [7:0] COL_BLACK   = 8'h00;

  // Bar index 0..7 to palette colour, left to right.
  function automatic logic [7:0] bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    return COL_WHITE;
      3'd1:    return COL_YELLOW;
      3'd2:    return COL_CYAN;
      3'd3:    return COL_GREEN;
      3'd4:    return COL_MAGENTA;
      3'd5:    return COL_RED;
      3'd6:    return COL_BLUE;
      default: return COL_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/clk_en_div.sv
// Clock-enable divider: registered one-clk strobe once every DIV clocks.
module clk_en_div #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic en
);

  localparam int unsigned DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] LAST = DW'(DIV - 1);

  logic [DW-1:0] div;
  logic [DW-1:0] div_nxt;

  always_comb begin
    div_nxt = (div == LAST) ? '0 : div + DW'(1);
  end

  // en is high in the same clk that div sits at its last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div <= '0;
      en  <= 1'b0;
    end else begin
      div <= div_nxt;
      en  <= (div_nxt == LAST);
    end
  end

endmodule

// File: rtl/vga_timing.sv
// VGA raster timing: pixel enable, hc/vc counters, syncs, blanking and frame tick.
// Optional colour-bar test pattern on rgb when VGA_TEST_PATTERN_EN is defined.
module vga_timing #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned H_VIS   = vga_pkg::H_VIS,
  parameter int unsigned H_FP    = vga_pkg::H_FP,
  parameter int unsigned H_SYNC  = vga_pkg::H_SYNC,
  parameter int unsigned H_BP    = vga_pkg::H_BP,
  parameter int unsigned V_VIS   = vga_pkg::V_VIS,
  parameter int unsigned V_FP    = vga_pkg::V_FP,
  parameter int unsigned V_SYNC  = vga_pkg::V_SYNC,
  parameter int unsigned V_BP    = vga_pkg::V_BP
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [9:0] hc,
  output logic [9:0] vc,
  output logic       pix_en,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       frame_tick,
  output logic [7:0] rgb
);

  import vga_pkg::*;

  localparam int unsigned H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

  localparam coord_t H_LAST  = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST  = coord_t'(V_TOTAL - 1);
  localparam coord_t H_VIS_C = coord_t'(H_VIS);
  localparam coord_t V_VIS_C = coord_t'(V_VIS);
  localparam coord_t HS_BEG  = coord_t'(H_VIS + H_FP);
  localparam coord_t HS_END  = coord_t'(H_VIS + H_FP + H_SYNC);
  localparam coord_t VS_BEG  = coord_t'(V_VIS + V_FP);
  localparam coord_t VS_END  = coord_t'(V_VIS + V_FP + V_SYNC);

  coord_t hc_nxt;
  coord_t vc_nxt;
  logic   hsync_nxt;
  logic   vsync_nxt;
  logic   video_nxt;
  logic   tick_nxt;

  clk_en_div #(.DIV(CLK_DIV)) u_pix_div (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (pix_en)
  );

  // Raster advance; decodes use the next coordinates so they line up with hc/vc.
  always_comb begin
    hc_nxt = hc;
    vc_nxt = vc;
    if (pix_en) begin
      if (hc == H_LAST) begin
        hc_nxt = '0;
        vc_nxt = (vc == V_LAST) ? '0 : vc + coord_t'(1);
      end else begin
        hc_nxt = hc + coord_t'(1);
      end
    end
    hsync_nxt = !((hc_nxt >= HS_BEG) && (hc_nxt < HS_END));
    vsync_nxt = !((vc_nxt >= VS_BEG) && (vc_nxt < VS_END));
    video_nxt = (hc_nxt < H_VIS_C) && (vc_nxt < V_VIS_C);
    tick_nxt  = pix_en && (hc_nxt == '0) && (vc_nxt == V_VIS_C);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hc         <= H_LAST;
      vc         <= V_LAST;
      hsync      <= 1'b1;
      vsync      <= 1'b1;
      video_on   <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      hc         <= hc_nxt;
      vc         <= vc_nxt;
      hsync      <= hsync_nxt;
      vsync      <= vsync_nxt;
      video_on   <= video_nxt;
      frame_tick <= tick_nxt;
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  localparam coord_t BAR_W = coord_t'(H_VIS / 8);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb <= 8'h00;
    end else begin
      rgb <= video_nxt ? bar_colour(3'(hc_nxt / BAR_W)) : 8'h00;
    end
  end
`else
  assign rgb = 8'h00;
`endif

endmodule

// File: tb/tb_vga_timing.sv
// Self-checking bench for vga_timing: default timing instance plus a tiny-raster CLK_DIV=1 instance.
module tb_vga_timing;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [9:0] a_hc, a_vc, b_hc, b_vc;
  logic a_pix, a_hs, a_vs, a_vo, a_ft;
  logic b_pix, b_hs, b_vs, b_vo, b_ft;
  logic [7:0] a_rgb, b_rgb;

  vga_timing dut_a (
    .clk(clk), .rst_n(rst_n), .hc(a_hc), .vc(a_vc), .pix_en(a_pix),
    .hsync(a_hs), .vsync(a_vs), .video_on(a_vo), .frame_tick(a_ft), .rgb(a_rgb)
  );

  vga_timing #(
    .CLK_DIV(1), .H_VIS(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_VIS(6), .V_FP(1), .V_SYNC(2), .V_BP(2)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .hc(b_hc), .vc(b_vc), .pix_en(b_pix),
    .hsync(b_hs), .vsync(b_vs), .video_on(b_vo), .frame_tick(b_ft), .rgb(b_rgb)
  );

  typedef struct packed {
    logic [9:0] hc;
    logic [9:0] vc;
    logic       pix_en;
    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic       frame_tick;
    logic [7:0] rgb;
  } obs_t;

  typedef struct {
    int         edges;
    logic [9:0] hc;
    logic [9:0] vc;
    logic       pix_en;
    logic       hsync;
    logic       video_on;
  } vec_t;

  localparam int HV [2] = '{640, 16};
  localparam int HF [2] = '{16, 2};
  localparam int HS [2] = '{96, 3};
  localparam int HB [2] = '{48, 3};
  localparam int VV [2] = '{480, 6};
  localparam int VF [2] = '{10, 1};
  localparam int VS [2] = '{2, 2};
  localparam int VB [2] = '{33, 2};
  localparam int DV [2] = '{4, 1};

`ifdef VGA_TEST_PATTERN_EN
  localparam logic [7:0] PAL [8] = '{8'hFF, 8'hFC, 8'h1F, 8'h1C, 8'hE3, 8'hE0, 8'h03, 8'h00};
`endif

  int checks = 0;
  int fails = 0;

  // Model state: clk edges since release, pixel advances so far, advance on the last edge.
  longint k [2];
  longint a [2];
  bit     adv [2];

  function automatic bit pix_of(int i);
    return (k[i] >= 1) && ((k[i] % DV[i]) == DV[i] - 1);
  endfunction

  // Raster position is the linear pixel index (start one before 0,0) split into line/column.
  function automatic obs_t model(int i);
    obs_t o;
    longint ht, vt, lin;
    int h, v;
    ht  = HV[i] + HF[i] + HS[i] + HB[i];
    vt  = VV[i] + VF[i] + VS[i] + VB[i];
    lin = (ht * vt - 1 + a[i]) % (ht * vt);
    h   = int'(lin % ht);
    v   = int'(lin / ht);
    o.hc         = 10'(h);
    o.vc         = 10'(v);
    o.pix_en     = pix_of(i);
    o.hsync      = !((h >= HV[i] + HF[i]) && (h < HV[i] + HF[i] + HS[i]));
    o.vsync      = !((v >= VV[i] + VF[i]) && (v < VV[i] + VF[i] + VS[i]));
    o.video_on   = (h < HV[i]) && (v < VV[i]);
    o.frame_tick = adv[i] && (h == 0) && (v == VV[i]);
    o.rgb        = 8'h00;
`ifdef VGA_TEST_PATTERN_EN
    if (o.video_on) o.rgb = PAL[h / (HV[i] / 8)];
`endif
    return o;
  endfunction

  function automatic obs_t got(int i);
    obs_t o;
    if (i == 0) o = {a_hc, a_vc, a_pix, a_hs, a_vs, a_vo, a_ft, a_rgb};
    else        o = {b_hc, b_vc, b_pix, b_hs, b_vs, b_vo, b_ft, b_rgb};
    return o;
  endfunction

  task automatic chk(input string nm, input logic [32:0] act, input logic [32:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: actual %h required %h", nm, act, req);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      k[i] = 0; a[i] = 0; adv[i] = 1'b0;
    end
  endtask

  // One clk edge: advance the model (if out of reset), then sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        adv[i] = pix_of(i);
        k[i]++;
        if (adv[i]) a[i]++;
      end
    end
    #1;
    chk("cycle_a", got(0), model(0));
    chk("cycle_b", got(1), model(1));
  endtask

  // Reset asserted between edges; outputs must return to reset values without a clk edge.
  task automatic mid_reset(input int hold);
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_reset_a", got(0), model(0));
    chk("async_reset_b", got(1), model(1));
    repeat (hold) step();
    @(negedge clk) rst_n = 1'b1;
  endtask

  vec_t vecs [13];
  int   e;
  int   cnt;
  int   last_tick;
  bit   found;

  initial begin
    vecs[0]  = '{0,    10'd799, 10'd524, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{3,    10'd799, 10'd524, 1'b1, 1'b1, 1'b0};
    vecs[2]  = '{4,    10'd0,   10'd0,   1'b0, 1'b1, 1'b1};
    vecs[3]  = '{7,    10'd0,   10'd0,   1'b1, 1'b1, 1'b1};
    vecs[4]  = '{8,    10'd1,   10'd0,   1'b0, 1'b1, 1'b1};
    vecs[5]  = '{2560, 10'd639, 10'd0,   1'b0, 1'b1, 1'b1};
    vecs[6]  = '{2564, 10'd640, 10'd0,   1'b0, 1'b1, 1'b0};
    vecs[7]  = '{2624, 10'd655, 10'd0,   1'b0, 1'b1, 1'b0};
    vecs[8]  = '{2628, 10'd656, 10'd0,   1'b0, 1'b0, 1'b0};
    vecs[9]  = '{3008, 10'd751, 10'd0,   1'b0, 1'b0, 1'b0};
    vecs[10] = '{3012, 10'd752, 10'd0,   1'b0, 1'b1, 1'b0};
    vecs[11] = '{3200, 10'd799, 10'd0,   1'b0, 1'b1, 1'b0};
    vecs[12] = '{3204, 10'd0,   10'd1,   1'b0, 1'b1, 1'b1};

    model_reset();
    repeat (3) step();
    @(negedge clk) rst_n = 1'b1;
    #1;
    chk("reset_state_a", got(0), model(0));

    // Table of hand-computed raster points on the default instance.
    e = 0;
    for (int j = 0; j < 13; j++) begin
      while (e < vecs[j].edges) begin
        step();
        e++;
      end
      chk($sformatf("vec%0d_hc", j), 33'(a_hc), 33'(vecs[j].hc));
      chk($sformatf("vec%0d_vc", j), 33'(a_vc), 33'(vecs[j].vc));
      chk($sformatf("vec%0d_pix_en", j), 33'(a_pix), 33'(vecs[j].pix_en));
      chk($sformatf("vec%0d_hsync", j), 33'(a_hs), 33'(vecs[j].hsync));
      chk($sformatf("vec%0d_video_on", j), 33'(a_vo), 33'(vecs[j].video_on));
      chk($sformatf("vec%0d_vsync", j), 33'(a_vs), 33'(1));
    end

    // Line 1: hsync low for 96 pixels of 4 clks each.
    cnt = 0;
    repeat (3200) begin
      step();
      if (!a_hs) cnt++;
    end
    chk("hsync_low_clks", 33'(cnt), 33'(384));
    chk("line2_vc", 33'(a_vc), 33'(2));

    // Tiny raster: 264 clks per frame; three frames of ticks and vsync.
    cnt = 0;
    last_tick = -1;
    e = 0;
    for (int n = 0; n < 3 * 264; n++) begin
      step();
      if (!b_vs) e++;
      if (b_ft) begin
        if (last_tick >= 0) chk("tick_period", 33'(n - last_tick), 33'(264));
        last_tick = n;
        cnt++;
      end
    end
    chk("tick_count", 33'(cnt), 33'(3));
    chk("vsync_low_clks", 33'(e), 33'(3 * 2 * 24));

    // Mid-line reset on the tiny raster at (10,3), then the release sequence again.
    found = 1'b0;
    for (int n = 0; n < 400 && !found; n++) begin
      step();
      if (b_hc == 10'd10 && b_vc == 10'd3) found = 1'b1;
    end
    chk("mid_line_reach", 33'(found), 33'(1));
    mid_reset(2);
    repeat (3) step();
    chk("rerelease_pix_en", 33'(a_pix), 33'(1));
    chk("rerelease_hc_hold", 33'(a_hc), 33'(799));
    step();
    chk("rerelease_hc", 33'(a_hc), 33'(0));
    chk("rerelease_vc", 33'(a_vc), 33'(0));
    chk("rerelease_video_on", 33'(a_vo), 33'(1));

    // Free run with occasional random resets, checked against the model every clk.
    for (int n = 0; n < 15000; n++) begin
      step();
      if ($urandom_range(0, 2999) == 0) mid_reset(int'($urandom_range(1, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/vga_timing.md
Name: vga_timing

Overview:
- Produces the raster coordinates hc/vc and the sync/blanking strobes consumed by the sprite blocks (frog, cars, logs), the colour mux and the VGA pins.
- Divides the 100 MHz system clk into a 25 MHz pixel-enable strobe.
- Generates 640x480@60 timing.
- Emits a once-per-frame tick, which game logic uses to pace movement and collision updates.

Parameters:
- CLK_DIV, 4, system clocks per pixel (at least 1; 1 means one pixel every clk).
- H_VIS, 640, visible pixels per line.
- H_FP, 16, horizontal front porch in pixels.
- H_SYNC, 96, hsync pulse width in pixels.
- H_BP, 48, horizontal back porch in pixels.
- V_VIS, 480, visible lines.
- V_FP, 10, vertical front porch in lines.
- V_SYNC, 2, vsync pulse width in lines.
- V_BP, 33, vertical back porch in lines.

Ports:
- clk  input  1  system clock, 100 MHz.
- rst_n  input  1  asynchronous active-low reset.
- hc  output  10  horizontal pixel counter; 0 is the first visible pixel.
- vc  output  10  vertical line counter; 0 is the first visible line.
- pix_en  output  1  one-clk strobe, once every CLK_DIV clks.
- hsync  output  1  horizontal sync, active low.
- vsync  output  1  vertical sync, active low.
- video_on  output  1  high while hc < H_VIS and vc < V_VIS.
- frame_tick  output  1  one-clk pulse at the start of vertical blanking.
- rgb  output  8  test-pattern colour, RRRGGGBB.

Behaviour:
- Reset: asynchronous on rst_n low, regardless of clk.
  - div = 0, hc = H_TOT-1 (799), vc = V_TOT-1 (524).
  - hsync = 1, vsync = 1, video_on = 0, pix_en = 0, frame_tick = 0, rgb = 0.
  - Counters reset to the last pixel so that the first advance lands on (0,0).
- Derived totals: H_TOT = H_VIS+H_FP+H_SYNC+H_BP = 800; V_TOT = 525.
- Divider:
  - div counts 0..CLK_DIV-1 and wraps to 0.
  - pix_en is registered and high for the one clk in which div == CLK_DIV-1.
  - The first pix_en after reset release occurs in the CLK_DIV-th clk.
- Counter advance, on a clk edge where pix_en == 1:
  - If hc == H_TOT-1: hc <= 0, and vc <= (vc == V_TOT-1) ? 0 : vc+1.
  - Otherwise hc <= hc+1 and vc holds.
  - No advance occurs when pix_en == 0.
- Decoded outputs (hsync, vsync, video_on) are registered and are computed from the next values of hc/vc, so they are aligned with hc/vc in the same cycle with zero-cycle skew.
  - hsync = 0 iff H_VIS+H_FP <= hc < H_VIS+H_FP+H_SYNC, i.e. 656..751.
  - vsync = 0 iff V_VIS+V_FP <= vc < V_VIS+V_FP+V_SYNC, i.e. 490..491. vsync changes only at the hc wrap.
  - video_on = (hc < H_VIS) && (vc < V_VIS).
- frame_tick:
  - High for exactly one clk: the clk after the edge on which (hc,vc) becomes (0,V_VIS).
  - Never asserted twice per frame.
  - Not asserted during the first partial frame unless vc actually reaches V_VIS.
- Width rules:
  - All counters are 10-bit unsigned.
  - Parameters must satisfy H_TOT <= 1024 and V_TOT <= 1024.
  - div is clog2(CLK_DIV) bits, with a minimum of 1.
- Reset mid-frame: all outputs return to their reset values immediately. Timing restarts from (799,524) with no residual pix_en phase.
- Blanking: rgb = 0 whenever video_on == 0, with or without the optional feature.

Optional Feature:
- Macro: VGA_TEST_PATTERN_EN.
- Defined:
  - rgb shows 8 vertical colour bars, each H_VIS/8 = 80 pixels wide.
  - The bar index is hc[9:0]/80; colours in order are white, yellow, cyan, green, magenta, red, blue, black.
  - rgb is registered with the same alignment as video_on.
- Undefined: rgb is tied to 8'h00 and no pattern logic is synthesised.
- Port list is identical in both cases.

Decomposition:
- Package vga_pkg holds:
  - H_*/V_* default timing constants, H_TOT/V_TOT;
  - colour constants for the bar palette (RRRGGGBB);
  - a coord_t typedef (10-bit).
- One natural sub-module: clk_en_div.
  - Parameter DIV; inputs clk, rst_n; output en.
  - Generates pix_en and is reusable for button-sampling enables.
- Counters and decodes stay in vga_timing.

Test Plan:
- Reset release with CLK_DIV=4: pix_en first high in the 4th clk; after that edge hc=0, vc=0, video_on=1, hsync=1, vsync=1.
- One line: hsync low starting at hc=656 and lasting exactly 96 pix_en (384 clk); the hc wrap at 799 increments vc by 1; video_on falls at hc=640.
- Full frame: vsync low for exactly 2 lines (vc 490..491, 1600 pixels); frame_tick pulses once per 420000 pix_en (1,680,000 clk), with 1-clk width, coincident with vc=480, hc=0.
- Reset mid-line at hc=300, vc=100 asserted between clk edges: outputs return to reset values asynchronously; after release the sequence matches the first scenario.
- CLK_DIV=1 override: pix_en constantly high; hc increments every clk; the frame period is 420000 clk.
- VGA_TEST_PATTERN_EN defined:
  - hc=0 gives rgb=FF, hc=80 gives FC (yellow), hc=639 gives 00 (black);
  - any hc>=640 or vc>=480 gives rgb=00.
  - Macro undefined: rgb always 00.
